// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the receive FIFO and the host
// bridge so they agree on character width and on the stored entry layout.
//   UART_DATA_W  : data bits per character
//   uart_char_t  : one stored character, {ferr, data}
//   UART_ENTRY_W : width of uart_char_t
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef struct packed {
      logic                   ferr;   // stop bit sampled low
      logic [UART_DATA_W-1:0] data;
   } uart_char_t;

   localparam int UART_ENTRY_W = $bits(uart_char_t);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Write (receiver strobe) and read (FWFT valid/ready) channels of the receive
// FIFO.
//   master : the environment side; drives wr_* and rd_ready
//   slave  : the FIFO side; drives rd_valid, rd_data, rd_ferr
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_DATA_W
);

   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ferr;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;
   logic             rd_ferr;

   modport master (
      output wr_valid, wr_data, wr_ferr, rd_ready,
      input  rd_valid, rd_data, rd_ferr
   );

   modport slave (
      input  wr_valid, wr_data, wr_ferr, rd_ready,
      output rd_valid, rd_data, rd_ferr
   );

endinterface

// File: rtl/uart_fifo_ctrl.sv
// Pointer/occupancy controller for a UART character FIFO; it holds no data,
// so the transmit FIFO can reuse it unchanged.
//   clk, rst        : clock, synchronous active-high reset
//   wr_valid        : write request
//   rd_ready        : consumer accepts head entry
//   push/pop/drop   : decoded events for this cycle
//   wr_ptr/rd_ptr   : storage addresses
//   count           : occupancy 0..DEPTH
//   full/empty/almost_full/rd_valid : flags decoded from count
module uart_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12,
   parameter int PW       = $clog2(DEPTH),
   parameter int CW       = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   input  logic          rd_ready,
   output logic          push,
   output logic          pop,
   output logic          drop,
   output logic [PW-1:0] wr_ptr,
   output logic [PW-1:0] rd_ptr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          rd_valid
);

   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign almost_full = (count >= CW'(AF_LEVEL));
   assign rd_valid    = ~empty;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // write when the head is being consumed.
   assign pop  = rd_valid & rd_ready;
   assign push = wr_valid & (~full | pop);
   assign drop = wr_valid & full & ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive character buffer behind the UART receiver. Stores {ferr, data} per
// character and presents the head first-word-fall-through. Characters arriving
// while full are dropped and recorded in a sticky flag and saturating counter.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : write strobe channel and FWFT read channel (slave side)
//   count       : occupancy 0..DEPTH
//   full, empty, almost_full : occupancy flags
//   overrun     : sticky, a character was dropped
//   ovr_clr     : clears overrun and drop_cnt (a same-cycle drop wins)
//   drop_cnt    : dropped characters, saturating at 255
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int WIDTH    = UART_DATA_W,
   parameter int AF_LEVEL = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   uart_rx_fifo_if.slave              bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       overrun,
   input  logic                       ovr_clr,
   output logic [7:0]                 drop_cnt
);

   localparam int PW = $clog2(DEPTH);

   logic          push, pop, drop;
   logic [PW-1:0] wr_ptr, rd_ptr;

   // Storage is deliberately not reset; entries are only readable after a push.
   logic [DEPTH-1:0][WIDTH:0] mem;

   uart_fifo_ctrl #(
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (bus.wr_valid),
      .rd_ready    (bus.rd_ready),
      .push        (push),
      .pop         (pop),
      .drop        (drop),
      .wr_ptr      (wr_ptr),
      .rd_ptr      (rd_ptr),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .rd_valid    (bus.rd_valid)
   );

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= {bus.wr_ferr, bus.wr_data};
   end

   assign bus.rd_data = mem[rd_ptr][WIDTH-1:0];
   assign bus.rd_ferr = mem[rd_ptr][WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overrun <= 1'b1;
         // A clear coinciding with a drop restarts the count at this drop.
         if (ovr_clr)              drop_cnt <= 8'd1;
         else if (drop_cnt != '1)  drop_cnt <= drop_cnt + 8'd1;
      end else if (ovr_clr) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int AF    = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ovr_clr = 1'b0;
   logic [4:0] count;
   logic       full, empty, almost_full, overrun;
   logic [7:0] drop_cnt;

   uart_rx_fifo_if #(.WIDTH(UART_DATA_W)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_W), .AF_LEVEL(AF)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .overrun     (overrun),
      .ovr_clr     (ovr_clr),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of stored characters plus overrun state.
   logic [8:0] mq[$];
   bit         m_ovr;
   int         m_drop;
   int         n_cmp = 0;
   int         n_err = 0;

   // One clock cycle of stimulus; the model advances at the same edge.
   task automatic step(input logic r, input logic wv, input logic [7:0] wd,
                       input logic wf, input logic rr, input logic oc);
      bit p_pop, p_full, p_push, p_drop;
      rst = r; bus.wr_valid = wv; bus.wr_data = wd; bus.wr_ferr = wf;
      bus.rd_ready = rr; ovr_clr = oc;
      @(posedge clk);
      if (r) begin
         mq.delete(); m_ovr = 0; m_drop = 0;
      end else begin
         p_pop  = (mq.size() != 0) && rr;
         p_full = (mq.size() == DEPTH);
         p_push = wv && (!p_full || p_pop);
         p_drop = wv && p_full && !p_pop;
         if (p_pop)  void'(mq.pop_front());
         if (p_push) mq.push_back({wf, wd});
         if (p_drop) begin
            m_ovr = 1;
            if (oc) m_drop = 0;
            if (m_drop < 255) m_drop++;
         end else if (oc) begin
            m_ovr = 0; m_drop = 0;
         end
      end
      #1;
      rst = 0; bus.wr_valid = 0; bus.wr_data = '0; bus.wr_ferr = 0;
      bus.rd_ready = 0; ovr_clr = 0;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
      n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_err++; $display("FAIL reset_flags got full=%b af=%b want 0 0", full, almost_full); end
      n_cmp++; if (overrun !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_ovr got %b/%0d want 0/0", overrun, drop_cnt); end
   endtask

   task automatic test_basic();
      logic [8:0] vals [3];
      vals[0] = {1'b0, 8'h41}; vals[1] = {1'b1, 8'h42}; vals[2] = {1'b0, 8'h43};
      for (int i = 0; i < 3; i++) step(0, 1, vals[i][7:0], vals[i][8], 0, 0);
      n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL basic_count got %0d want 3", count); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (bus.rd_valid !== 1'b1 || {bus.rd_ferr, bus.rd_data} !== vals[i])
            begin n_err++; $display("FAIL basic_head%0d got v=%b %h want 1 %h", i, bus.rd_valid, {bus.rd_ferr, bus.rd_data}, vals[i]); end
         step(0, 0, 0, 0, 1, 0);
      end
      n_cmp++; if (empty !== 1'b1 || bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty got %b/%b want 1/0", empty, bus.rd_valid); end
   endtask

   task automatic fill16();
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 1, 8'(i), 1'(i % 3 == 0), 0, 0);
         n_cmp++;
         if (almost_full !== (mq.size() >= AF) || full !== (mq.size() == DEPTH) || count !== 5'(mq.size()))
            begin n_err++; $display("FAIL fill_flags n=%0d got af=%b full=%b cnt=%0d want %b %b %0d", mq.size(), almost_full, full, count, mq.size() >= AF, mq.size() == DEPTH, mq.size()); end
      end
   endtask

   task automatic drain_check(input string tag);
      int n;
      n = mq.size();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (bus.rd_valid !== 1'b1 || {bus.rd_ferr, bus.rd_data} !== mq[0])
            begin n_err++; $display("FAIL %s_head%0d got v=%b %h want 1 %h", tag, i, bus.rd_valid, {bus.rd_ferr, bus.rd_data}, mq[0]); end
         step(0, 0, 0, 0, 1, 0);
      end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL %s_empty got %b want 1", tag, empty); end
   endtask

   task automatic test_fill_overrun();
      fill16();
      step(0, 1, 8'hAA, 0, 0, 0);
      n_cmp++; if (overrun !== 1'b1 || drop_cnt !== 8'd1) begin n_err++; $display("FAIL ovr_first got %b/%0d want 1/1", overrun, drop_cnt); end
      n_cmp++; if (count !== 5'd16 || full !== 1'b1) begin n_err++; $display("FAIL ovr_count got %0d/%b want 16/1", count, full); end
      drain_check("ovr_drain");
   endtask

   task automatic test_full_simul();
      fill16();
      n_cmp++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL simul_head got %h want 00", bus.rd_data); end
      step(0, 1, 8'h55, 0, 1, 0);
      n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL simul_count got %0d want 16", count); end
      n_cmp++; if (overrun !== m_ovr || drop_cnt !== 8'(m_drop)) begin n_err++; $display("FAIL simul_ovr got %b/%0d want %b/%0d", overrun, drop_cnt, m_ovr, m_drop); end
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 1, 0);
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h55) begin n_err++; $display("FAIL simul_tail got %b/%h want 1/55", bus.rd_valid, bus.rd_data); end
      drain_check("simul");
   endtask

   task automatic test_ovr_clr();
      fill16();
      step(0, 1, 8'h11, 0, 0, 0);
      step(0, 1, 8'h12, 0, 0, 1);
      n_cmp++; if (overrun !== 1'b1 || drop_cnt !== 8'd1) begin n_err++; $display("FAIL clr_drop_wins got %b/%0d want 1/1", overrun, drop_cnt); end
      step(0, 0, 0, 0, 0, 1);
      n_cmp++; if (overrun !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL clr_alone got %b/%0d want 0/0", overrun, drop_cnt); end
      for (int i = 0; i < 300; i++) step(0, 1, 8'(i), 0, 0, 0);
      n_cmp++; if (drop_cnt !== 8'd255 || overrun !== 1'b1) begin n_err++; $display("FAIL clr_saturate got %b/%0d want 1/255", overrun, drop_cnt); end
      step(0, 0, 0, 0, 0, 1);
      drain_check("clr");
   endtask

   task automatic test_wrap();
      step(0, 1, 8'd0, 0, 1, 0);
      for (int i = 1; i < 40; i++) begin
         n_cmp++; if (bus.rd_data !== 8'(i - 1)) begin n_err++; $display("FAIL wrap_order%0d got %h want %h", i, bus.rd_data, 8'(i - 1)); end
         step(0, 1, 8'(i), 0, 1, 0);
         n_cmp++; if (count > 5'd1) begin n_err++; $display("FAIL wrap_count%0d got %0d want <=1", i, count); end
      end
      drain_check("wrap");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hC0 + i), 0, 0, 0);
      n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL rstmid_pre got %0d want 5", count); end
      step(1, 1, 8'hEE, 0, 1, 0);
      n_cmp++; if (empty !== 1'b1 || count !== 5'd0 || bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rstmid got e=%b c=%0d v=%b want 1 0 0", empty, count, bus.rd_valid); end
   endtask

   task automatic test_random();
      logic wv, rr, oc;
      for (int c = 0; c < 600; c++) begin
         n_cmp++;
         if (bus.rd_valid !== (mq.size() != 0) || (mq.size() != 0 && {bus.rd_ferr, bus.rd_data} !== mq[0]))
            begin n_err++; $display("FAIL rand_head c=%0d got v=%b %h want %b %h", c, bus.rd_valid, {bus.rd_ferr, bus.rd_data}, mq.size() != 0, (mq.size() != 0) ? mq[0] : 9'h0); end
         // Bias toward writes in the first half to reach full and overrun.
         wv = ($urandom_range(99) < ((c < 300) ? 75 : 40));
         rr = ($urandom_range(99) < ((c < 300) ? 30 : 60));
         oc = ($urandom_range(99) < 4);
         step(0, wv, 8'($urandom), 1'($urandom), rr, oc);
         n_cmp++;
         if (count !== 5'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
             almost_full !== (mq.size() >= AF) || overrun !== m_ovr || drop_cnt !== 8'(m_drop))
            begin n_err++; $display("FAIL rand_state c=%0d got cnt=%0d f=%b e=%b af=%b o=%b d=%0d want %0d ovr=%b d=%0d", c, count, full, empty, almost_full, overrun, drop_cnt, mq.size(), m_ovr, m_drop); end
      end
   endtask

   initial begin
      bus.wr_valid = 0; bus.wr_data = '0; bus.wr_ferr = 0; bus.rd_ready = 0;
      test_reset();
      test_basic();
      test_fill_overrun();
      test_full_simul();
      test_ovr_clr();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
